alu_issue_stage: RTL and testbench

- Registered issue stage directly upstream of the ALU result multiplexer.
- Each cycle it can accept one decoded operation (ALUOp, funct3, funct7[5], R/I type, two operands) over a valid/ready handshake.
- It translates the fields into the 4-bit ALU select code and presents select plus operands to the ALU/mux downstream.
- A 2-entry skid buffer keeps in_ready_o registered, so downstream stalls never produce a combinational ready path.

---
 rtl/alu_issue_stage.sv | 159 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with 2-entry skid buffer
module alu_issue_stage #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [1:0]   alu_op_i,
    input  logic [2:0]   funct3_i,
    input  logic         funct7b5_i,
    input  logic         r_type_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [3:0]   sel_o,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic         illegal_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_BAD = 4'b1111;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           emit;

    logic [3:0]     dec_sel;
    logic           dec_ill;
    logic [3:0]     main_sel;
    logic           main_ill;
    logic [N-1:0]   main_a;
    logic [N-1:0]   main_b;
    logic [3:0]     skid_sel;
    logic           skid_ill;
    logic [N-1:0]   skid_a;
    logic [N-1:0]   skid_b;

    // A flushed cycle never captures, even though in_ready_o was high.
    assign accept = in_valid_i & in_ready_o & ~flush_i;
    assign emit   = out_valid_o & out_ready_i;

    always_comb begin
        dec_sel = SEL_BAD;
        dec_ill = 1'b1;
        case (alu_op_i)
            2'b00: begin
                dec_sel = SEL_ADD;
                dec_ill = 1'b0;
            end
            2'b01: begin
                dec_sel = SEL_SUB;
                dec_ill = 1'b0;
            end
            2'b10: begin
                case (funct3_i)
                    3'b000: begin
                        dec_sel = (r_type_i & funct7b5_i) ? SEL_SUB : SEL_ADD;
                        dec_ill = 1'b0;
                    end
                    3'b111: begin
                        dec_sel = SEL_AND;
                        dec_ill = 1'b0;
                    end
                    3'b110: begin
                        dec_sel = SEL_OR;
                        dec_ill = 1'b0;
                    end
                    default: begin
                        dec_sel = SEL_BAD;
                        dec_ill = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_sel = SEL_BAD;
                dec_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !emit) state_nxt = TWO;
                    else if (!accept && emit) state_nxt = EMPTY;
                end
                TWO:     if (emit) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready_o  = (state != TWO);
        out_valid_o = (state != EMPTY);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_sel <= '0;
            main_ill <= 1'b0;
            main_a   <= '0;
            main_b   <= '0;
        end else if ((state == EMPTY && accept) || (state == ONE && accept && emit)) begin
            main_sel <= dec_sel;
            main_ill <= dec_ill;
            main_a   <= a_i;
            main_b   <= b_i;
        end else if (state == TWO && emit) begin
            main_sel <= skid_sel;
            main_ill <= skid_ill;
            main_a   <= skid_a;
            main_b   <= skid_b;
        end
    end

    // Skid only fills when main is occupied and stalled; its contents need no reset.
    always_ff @(posedge clk_i) begin
        if (state == ONE && accept && !emit) begin
            skid_sel <= dec_sel;
            skid_ill <= dec_ill;
            skid_a   <= a_i;
            skid_b   <= b_i;
        end
    end

    assign sel_o     = main_sel;
    assign illegal_o = main_ill;
    assign a_o       = main_a;
    assign b_o       = main_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        r_type = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  sel;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        illegal;

    typedef struct packed {
        logic [3:0]  sel;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.N(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .alu_op_i    (alu_op),
        .funct3_i    (funct3),
        .funct7b5_i  (funct7b5),
        .r_type_i    (r_type),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sel_o       (sel),
        .a_o         (a_out),
        .b_o         (b_out),
        .illegal_o   (illegal)
    );

    function automatic ent_t ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f7, input logic rt,
                                        input logic [31:0] va, input logic [31:0] vb);
        ent_t e;
        e.a = va;
        e.b = vb;
        e.ill = 1'b0;
        if (op == 2'd0) e.sel = 4'd2;
        else if (op == 2'd1) e.sel = 4'd6;
        else if (op == 2'd2 && f3 == 3'd0) e.sel = (rt && f7) ? 4'd6 : 4'd2;
        else if (op == 2'd2 && f3 == 3'd7) e.sel = 4'd0;
        else if (op == 2'd2 && f3 == 3'd6) e.sel = 4'd1;
        else begin
            e.sel = 4'd15;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // One clock edge with the reference FIFO updated from the pre-edge inputs.
    task automatic tick();
        bit rdy;
        bit emit;
        ent_t e;
        rdy  = (q.size() < 2);
        emit = (q.size() > 0) && out_ready;
        e    = ref_decode(alu_op, funct3, funct7b5, r_type, a, b);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && rdy) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic rt, input logic [31:0] va, input logic [31:0] vb);
        alu_op = op; funct3 = f3; funct7b5 = f7; r_type = rt; a = va; b = vb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        drive(2'd2, 3'd0, 1'b1, 1'b1, 32'h55, 32'h66);
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel !== 4'd0 ||
            a_out !== 32'd0 || b_out !== 32'd0 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got v=%b r=%b sel=%h a=%h b=%h ill=%b exp v=0 r=1 sel=0 a=0 b=0 ill=0",
                     out_valid, in_ready, sel, a_out, b_out, illegal);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_no_capture got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_stream();
        logic [2:0] f3s [3] = '{3'd0, 3'd7, 3'd6};
        logic [3:0] exps[3] = '{4'b0110, 4'b0000, 4'b0001};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'd2, f3s[i], 1'b1, 1'b1, 32'd7, 32'd3);
            tick();
            tests++;
            if (out_valid !== 1'b1 || sel !== exps[i] || a_out !== 32'd7 ||
                b_out !== 32'd3 || illegal !== 1'b0) begin
                fails++;
                $display("FAIL stream_%0d got v=%b sel=%b a=%0d b=%0d ill=%b exp v=1 sel=%b a=7 b=3 ill=0",
                         i, out_valid, sel, a_out, b_out, illegal, exps[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_decode();
        logic [1:0] ops [5] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [2:0] f3s [5] = '{3'd0, 3'd3, 3'd5, 3'd1, 3'd0};
        logic       rts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exps[5] = '{4'b0010, 4'b0010, 4'b0110, 4'b1111, 4'b1111};
        logic       ills[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            drive(ops[i], f3s[i], 1'b1, rts[i], 32'h100 + i, 32'h200 + i);
            tick();
            in_valid = 1'b0;
            tests++;
            if (out_valid !== 1'b1 || sel !== exps[i] || illegal !== ills[i] ||
                a_out !== 32'h100 + i) begin
                fails++;
                $display("FAIL decode_%0d got v=%b sel=%b ill=%b a=%h exp v=1 sel=%b ill=%b a=%h",
                         i, out_valid, sel, illegal, a_out, exps[i], ills[i], 32'h100 + i);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen[$];
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'd0, 3'd0, 1'b0, 1'b0, 32'hA, 32'h1);
        tick();
        drive(2'd0, 3'd0, 1'b0, 1'b0, 32'hB, 32'h2);
        tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || a_out !== 32'hA) begin
            fails++;
            $display("FAIL b2b_full got r=%b v=%b a=%h exp r=0 v=1 a=a", in_ready, out_valid, a_out);
        end
        drive(2'd0, 3'd0, 1'b0, 1'b0, 32'hC, 32'h3);
        tick();
        tests++;
        if (in_ready !== 1'b0 || a_out !== 32'hA) begin
            fails++;
            $display("FAIL b2b_hold got r=%b a=%h exp r=0 a=a", in_ready, a_out);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1) seen.push_back(a_out);
            if (in_valid && in_ready === 1'b1) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        tests++;
        if (seen.size() != 3 || seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin
            fails++;
            $display("FAIL b2b_order got n=%0d %p exp A B C", seen.size(), seen);
        end
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_empty got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(2'd1, 3'd0, 1'b0, 1'b0, 32'h11, 32'h0);
        tick();
        drive(2'd1, 3'd0, 1'b0, 1'b0, 32'h22, 32'h0);
        tick();
        drive(2'd1, 3'd0, 1'b0, 1'b0, 32'hDD, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_two got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        // Flush in ONE while in_ready is high: presented op must still drop.
        drive(2'd1, 3'd0, 1'b0, 1'b0, 32'h33, 32'h0);
        tick();
        drive(2'd1, 3'd0, 1'b0, 1'b0, 32'hEE, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_drop got v=%b r=%b a=%h exp v=0 r=1", out_valid, in_ready, a_out);
        end
    endtask

    task automatic test_random();
        bit          held;
        bit          stall;
        bit          was_rst;
        logic [3:0]  p_sel;
        logic [31:0] p_a;
        logic [31:0] p_b;
        logic        p_ill;
        int          nprint = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            held = in_valid && (q.size() == 2) && !flush && !rst;
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
                      1'($urandom), $urandom, $urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            stall   = out_valid && !out_ready && !flush && !rst;
            was_rst = rst;
            p_sel = sel; p_a = a_out; p_b = b_out; p_ill = illegal;
            tick();
            tests++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                fails++;
                if (nprint++ < 20)
                    $display("FAIL rand_flags cyc=%0d got v=%b r=%b exp v=%b r=%b",
                             cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                tests++;
                if (sel !== q[0].sel || illegal !== q[0].ill || a_out !== q[0].a || b_out !== q[0].b) begin
                    fails++;
                    if (nprint++ < 20)
                        $display("FAIL rand_data cyc=%0d got sel=%h ill=%b a=%h b=%h exp sel=%h ill=%b a=%h b=%h",
                                 cyc, sel, illegal, a_out, b_out, q[0].sel, q[0].ill, q[0].a, q[0].b);
                end
            end
            if (stall) begin
                tests++;
                if (sel !== p_sel || a_out !== p_a || b_out !== p_b || illegal !== p_ill) begin
                    fails++;
                    if (nprint++ < 20)
                        $display("FAIL rand_stable cyc=%0d got sel=%h a=%h exp sel=%h a=%h",
                                 cyc, sel, a_out, p_sel, p_a);
                end
            end
            if (was_rst) begin
                tests++;
                if (sel !== 4'd0 || a_out !== 32'd0 || b_out !== 32'd0 || illegal !== 1'b0) begin
                    fails++;
                    if (nprint++ < 20)
                        $display("FAIL rand_reset cyc=%0d got sel=%h a=%h b=%h ill=%b exp zeros",
                                 cyc, sel, a_out, b_out, illegal);
                end
            end
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode();
        test_back_to_back();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
